// File: rtl/col_feeder_pkg.sv
// Shared types and helpers for the column feeder: FSM states and bank index arithmetic.
package col_feeder_pkg;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  function automatic int bank_w(input int nm);
    return (nm > 1) ? $clog2(nm) : 1;
  endfunction

  // Lane k sits k+1 rows after the bank currently being written, modulo the bank count.
  function automatic int lane_bank(input int wbank, input int lane, input int nm);
    return (wbank + 1 + lane) % nm;
  endfunction

endpackage

// File: rtl/line_bank.sv
// One row of pixel storage: single-port RAM, write or read per cycle, 1-cycle read latency.
// The read register is reset and holds its value on cycles without a read; the array is not reset.
module line_bank #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int PB    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [PB-1:0] wdata,
  output logic [PB-1:0] rdata
);

  logic [PB-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)             rdata <= '0;
    else if (re && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/col_feeder.sv
// Rolling line buffer: stores NM-1 rows, then emits one NM-pixel column per accepted pixel, one cycle later.
// No downstream backpressure; pix_ready is high only in FILL and STREAM.
module col_feeder
  import col_feeder_pkg::*;
#(
  parameter int XB    = 10,
  parameter int YB    = 10,
  parameter int PB    = 8,
  parameter int NM    = 4,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PB-1:0] pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [PB-1:0] col_data [NM-1:0],
  output logic          en,
  output logic          frame_done
);

  localparam int BW = bank_w(NM);
  localparam logic [XB-1:0] X_LAST    = XB'(IMG_W - 1);
  localparam logic [YB-1:0] Y_LAST    = YB'(IMG_H - 1);
  localparam logic [YB-1:0] Y_FILLEND = YB'(NM - 2);
  localparam logic [BW-1:0] B_LAST    = BW'(NM - 1);

  if (NM < 2 || IMG_H < NM) begin : g_bad_params
    $error("col_feeder: requires NM >= 2 and IMG_H >= NM");
  end

  state_t        state_q, state_d;
  logic [XB-1:0] x_q;
  logic [YB-1:0] y_q;
  logic [BW-1:0] wbank_q, wbank_d;
  logic [PB-1:0] live_q;
  logic [PB-1:0] rdata [NM-1:0];
  logic          accept, stream_acc, last_col, last_row;

  assign pix_ready  = (state_q == FILL) || (state_q == STREAM);
  assign accept     = pix_valid && pix_ready;
  assign stream_acc = accept && (state_q == STREAM);
  assign last_col   = (x_q == X_LAST);
  assign last_row   = (y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (accept && last_col && (y_q == Y_FILLEND)) state_d = STREAM;
      STREAM:  if (accept && last_col && last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      wbank_q    <= '0;
      wbank_d    <= '0;
      live_q     <= '0;
      en         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      en         <= stream_acc;
      frame_done <= stream_acc && last_col && last_row;
      if (state_q == IDLE && start) begin
        x_q     <= '0;
        y_q     <= '0;
        wbank_q <= '0;
      end else if (accept) begin
        if (last_col) begin
          x_q     <= '0;
          y_q     <= y_q + 1'b1;
          wbank_q <= (wbank_q == B_LAST) ? '0 : wbank_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      // Lane mapping and the live pixel only move on output beats, so col_data holds otherwise.
      if (stream_acc) begin
        live_q  <= pix_in;
        wbank_d <= wbank_q;
      end
    end
  end

  for (genvar b = 0; b < NM; b++) begin : g_bank
    line_bank #(.DEPTH(IMG_W), .AW(XB), .PB(PB)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (accept && (wbank_q == BW'(b))),
      .re    (stream_acc && (wbank_q != BW'(b))),
      .addr  (x_q),
      .wdata (pix_in),
      .rdata (rdata[b])
    );
  end

  for (genvar k = 0; k < NM - 1; k++) begin : g_lane
    logic [BW-1:0] sel;
    assign sel         = BW'(lane_bank(int'(wbank_d), k, NM));
    assign col_data[k] = rdata[sel];
  end
  assign col_data[NM-1] = live_q;

endmodule

// File: tb/tb_col_feeder.sv
// Directed bench for col_feeder on a 4x5 image with 4 banks; pixel value = base + 16*y + x.
module tb_col_feeder;
  localparam int XB = 2, YB = 3, PB = 8, NM = 4, W = 4, H = 5;

  logic          clk = 1'b0;
  logic          rst, start, pix_valid, pix_ready, en, frame_done;
  logic [PB-1:0] pix_in;
  logic [PB-1:0] col_data [NM-1:0];

  int tests = 0, fails = 0, en_cnt = 0, acc_cnt = 0;

  col_feeder #(.XB(XB), .YB(YB), .PB(PB), .NM(NM), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .col_data   (col_data),
    .en         (en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    logic acc;
    acc = pix_valid && pix_ready;
    @(posedge clk);
    #1;
    if (acc) acc_cnt++;
    if (en) en_cnt++;
  endtask

  task automatic send_pix(input logic [PB-1:0] v);
    pix_in    = v;
    pix_valid = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; pix_valid = 1'b0; pix_in = '0;
    step();
    step();
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", pix_ready); end
    tests++; if (en !== 1'b0) begin fails++; $display("FAIL reset_en got %b want 0", en); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", frame_done); end
    for (int k = 0; k < NM; k++) begin
      tests++;
      if (col_data[k] !== 8'h00) begin fails++; $display("FAIL reset_col%0d got %h want 00", k, col_data[k]); end
    end
    rst = 1'b0; start = 1'b0;
    step();
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL start_in_rst_ready got %b want 0", pix_ready); end
  endtask

  // start with pix_valid already high: that beat must not be taken, then 12 fill beats without en.
  task automatic test_fill(input logic [PB-1:0] base);
    start = 1'b1; pix_valid = 1'b1; pix_in = 8'hEE; acc_cnt = 0;
    step();
    tests++; if (acc_cnt !== 0) begin fails++; $display("FAIL start_beat_accepted got %0d want 0", acc_cnt); end
    start = 1'b0; acc_cnt = 0; en_cnt = 0;
    for (int y = 0; y < NM - 1; y++) begin
      for (int x = 0; x < W; x++) begin
        tests++;
        if (pix_ready !== 1'b1) begin fails++; $display("FAIL fill_ready y%0d x%0d got %b want 1", y, x, pix_ready); end
        send_pix(base + 8'(16 * y + x));
      end
    end
    tests++; if (acc_cnt !== 12) begin fails++; $display("FAIL fill_accepted got %0d want 12", acc_cnt); end
    tests++; if (en_cnt !== 0) begin fails++; $display("FAIL fill_en got %0d want 0", en_cnt); end
  endtask

  task automatic test_stream(input logic [PB-1:0] base);
    logic [PB-1:0] exp;
    en_cnt = 0;
    for (int y = NM - 1; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        send_pix(base + 8'(16 * y + x));
        tests++;
        if (en !== 1'b1) begin fails++; $display("FAIL stream_en y%0d x%0d got %b want 1", y, x, en); end
        for (int k = 0; k < NM; k++) begin
          exp = base + 8'(16 * (y - (NM - 1) + k) + x);
          tests++;
          if (col_data[k] !== exp) begin
            fails++; $display("FAIL stream_col y%0d x%0d lane%0d got %h want %h", y, x, k, col_data[k], exp);
          end
        end
        tests++;
        if (frame_done !== ((y == H - 1) && (x == W - 1))) begin
          fails++; $display("FAIL frame_done y%0d x%0d got %b", y, x, frame_done);
        end
      end
    end
    pix_valid = 1'b0;
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL done_ready got %b want 0", pix_ready); end
    step();
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL idle_ready got %b want 0", pix_ready); end
    tests++; if (en !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL idle_en got %b/%b want 0/0", en, frame_done); end
    tests++; if (col_data[3] !== base + 8'h43) begin fails++; $display("FAIL col_hold got %h want %h", col_data[3], base + 8'h43); end
    tests++; if (en_cnt !== 8) begin fails++; $display("FAIL en_count got %0d want 8", en_cnt); end
  endtask

  // Row 3 with idle gaps and stray start pulses, then reset while x=1 is being offered.
  task automatic test_gaps_rst(input logic [PB-1:0] base);
    int n;
    pix_valid = 1'b0; start = 1'b1;
    n = $urandom_range(1, 3);
    repeat (n) begin
      step();
      tests++; if (en !== 1'b0 || pix_ready !== 1'b1) begin fails++; $display("FAIL gap0 en/ready got %b/%b want 0/1", en, pix_ready); end
    end
    start = 1'b0;
    send_pix(base + 8'h30);
    tests++; if (en !== 1'b1) begin fails++; $display("FAIL gap_beat_en got %b want 1", en); end
    for (int k = 0; k < NM; k++) begin
      tests++;
      if (col_data[k] !== base + 8'(16 * k)) begin
        fails++; $display("FAIL gap_col lane%0d got %h want %h", k, col_data[k], base + 8'(16 * k));
      end
    end
    pix_valid = 1'b0; start = 1'b1;
    n = $urandom_range(1, 3);
    repeat (n) begin
      step();
      tests++; if (en !== 1'b0 || col_data[3] !== base + 8'h30) begin fails++; $display("FAIL gap1 en/col3 got %b/%h want 0/%h", en, col_data[3], base + 8'h30); end
    end
    start = 1'b0;
    rst = 1'b1; pix_valid = 1'b1; pix_in = base + 8'h31;
    step();
    tests++; if (en !== 1'b0 || pix_ready !== 1'b0) begin fails++; $display("FAIL midrst en/ready got %b/%b want 0/0", en, pix_ready); end
    tests++; if (col_data[0] !== 8'h00 || col_data[3] !== 8'h00) begin fails++; $display("FAIL midrst_col got %h/%h want 00/00", col_data[0], col_data[3]); end
    rst = 1'b0; pix_valid = 1'b0;
    step();
    tests++; if (pix_ready !== 1'b0 || en !== 1'b0) begin fails++; $display("FAIL post_rst_idle ready/en got %b/%b want 0/0", pix_ready, en); end
  endtask

  initial begin
    test_reset();
    test_fill(8'h00);
    test_stream(8'h00);
    test_fill(8'h80);
    test_gaps_rst(8'h80);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
